// File: rtl/mp_alu_seq.sv
// mp_alu_seq: multi-precision sequencer that drives a combinational byte ALU.
// It turns one NBYTES-wide ADD/SUB/LSL/LSR into a sequence of byte operations,
// collects each ALU result byte and reports the full-width result with flags.
// Optional feature: define MP_CARRY_IN_EN to add the carry_i port (initial
// carry/borrow/shift-in bit captured at start).
module mp_alu_seq #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned CW     = $clog2(NBYTES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [1:0]            op_sel_i,
  input  logic [8*NBYTES-1:0]   a_i,
  input  logic [8*NBYTES-1:0]   b_i,
`ifdef MP_CARRY_IN_EN
  input  logic                  carry_i,
`endif
  output logic [7:0]            alu_rs_o,
  output logic [7:0]            alu_rt_o,
  output logic [8:0]            alu_op_o,
  input  logic [7:0]            alu_result_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [8*NBYTES-1:0]   result_o,
  output logic                  carry_o,
  output logic                  neg_o,
  output logic                  zero_o
);

  localparam int unsigned W = 8 * NBYTES;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  // ALU opcodes: encoding lives in bits [8:1], bit 0 always 0
  localparam logic [8:0] OP_NOP  = 9'h000;
  localparam logic [8:0] OP_ADD  = 9'h002;
  localparam logic [8:0] OP_SUB  = 9'h006;
  localparam logic [8:0] OP_LSLC = 9'h00C;
  localparam logic [8:0] OP_LSRC = 9'h01C;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_LSL = 2'b10;
  localparam logic [1:0] SEL_LSR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [NBYTES-1:0][7:0] bytes_t;

  // Unsigned carry out of a byte add, derived from operand and result MSBs
  function automatic logic add_carry(input logic a7, input logic b7, input logic r7);
    return (a7 & b7) | ((a7 | b7) & ~r7);
  endfunction

  // Borrow out of a byte subtract, derived from operand and result MSBs
  function automatic logic sub_borrow(input logic a7, input logic b7, input logic r7);
    return (~a7 & b7) | ((~a7 | b7) & r7);
  endfunction

  function automatic logic [8:0] sel_to_op(input logic [1:0] sel);
    logic [8:0] op;
    case (sel)
      SEL_ADD: op = OP_ADD;
      SEL_SUB: op = OP_SUB;
      SEL_LSL: op = OP_LSLC;
      default: op = OP_LSRC;
    endcase
    return op;
  endfunction

  logic carry_init;
`ifdef MP_CARRY_IN_EN
  assign carry_init = carry_i;
`else
  assign carry_init = 1'b0;
`endif

  state_t       state_q, state_n;
  bytes_t       a_q, a_n;
  bytes_t       b_q, b_n;
  bytes_t       r_q, r_n;
  logic [1:0]   sel_q, sel_n;
  logic [CW-1:0] idx_q, idx_n;
  logic         cy_q, cy_n;
  logic         icy_q, icy_n;

  logic [7:0]   rs_n, rt_n;
  logic [8:0]   op_n;
  logic         busy_n, done_n;
  logic [W-1:0] result_n;
  logic         carry_n, neg_n, zero_n;

  logic         byte_cy;
  logic         go_issue;
  logic         go_done;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      sel_q    <= 2'b00;
      idx_q    <= '0;
      cy_q     <= 1'b0;
      icy_q    <= 1'b0;
      alu_rs_o <= 8'h00;
      alu_rt_o <= 8'h00;
      alu_op_o <= OP_NOP;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      carry_o  <= 1'b0;
      neg_o    <= 1'b0;
      zero_o   <= 1'b0;
    end else begin
      state_q  <= state_n;
      a_q      <= a_n;
      b_q      <= b_n;
      r_q      <= r_n;
      sel_q    <= sel_n;
      idx_q    <= idx_n;
      cy_q     <= cy_n;
      icy_q    <= icy_n;
      alu_rs_o <= rs_n;
      alu_rt_o <= rt_n;
      alu_op_o <= op_n;
      busy_o   <= busy_n;
      done_o   <= done_n;
      result_o <= result_n;
      carry_o  <= carry_n;
      neg_o    <= neg_n;
      zero_o   <= zero_n;
    end
  end

  // Next state, datapath updates and next ALU drive for the following cycle
  always_comb begin
    state_n  = state_q;
    a_n      = a_q;
    b_n      = b_q;
    r_n      = r_q;
    sel_n    = sel_q;
    idx_n    = idx_q;
    cy_n     = cy_q;
    icy_n    = icy_q;
    rs_n     = 8'h00;
    rt_n     = 8'h00;
    op_n     = OP_NOP;
    busy_n   = busy_o;
    done_n   = 1'b0;
    result_n = result_o;
    carry_n  = carry_o;
    neg_n    = neg_o;
    zero_n   = zero_o;
    byte_cy  = 1'b0;
    go_issue = 1'b0;
    go_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_n = 1'b0;
        if (start_i) begin
          a_n      = a_i;
          b_n      = b_i;
          sel_n    = op_sel_i;
          cy_n     = carry_init;
          icy_n    = 1'b0;
          idx_n    = (op_sel_i == SEL_LSR) ? LAST : '0;
          busy_n   = 1'b1;
          go_issue = 1'b1;
        end
      end

      ST_ISSUE: begin
        r_n[idx_q] = alu_result_i;
        if (!sel_q[1]) begin
          // ADD/SUB: carry comes from the byte MSBs, not the ALU flag
          byte_cy = sel_q[0] ? sub_borrow(a_q[idx_q][7], b_q[idx_q][7], alu_result_i[7])
                             : add_carry(a_q[idx_q][7], b_q[idx_q][7], alu_result_i[7]);
          if (cy_q) begin
            icy_n   = byte_cy;
            state_n = ST_FIXUP;
            rs_n    = alu_result_i;
            rt_n    = 8'h01;
            op_n    = alu_op_o;
          end else begin
            cy_n = byte_cy;
            if (idx_q == LAST) begin
              go_done = 1'b1;
            end else begin
              idx_n    = idx_q + CW'(1);
              go_issue = 1'b1;
            end
          end
        end else if (sel_q == SEL_LSL) begin
          cy_n = a_q[idx_q][7];
          if (idx_q == LAST) begin
            go_done = 1'b1;
          end else begin
            idx_n    = idx_q + CW'(1);
            go_issue = 1'b1;
          end
        end else begin
          cy_n = a_q[idx_q][0];
          if (idx_q == '0) begin
            go_done = 1'b1;
          end else begin
            idx_n    = idx_q - CW'(1);
            go_issue = 1'b1;
          end
        end
      end

      ST_FIXUP: begin
        // Apply the incoming carry/borrow as +/-1 on the partial byte
        r_n[idx_q] = alu_result_i;
        byte_cy = sel_q[0] ? sub_borrow(alu_rs_o[7], 1'b0, alu_result_i[7])
                           : add_carry(alu_rs_o[7], 1'b0, alu_result_i[7]);
        cy_n = icy_q | byte_cy;
        if (idx_q == LAST) begin
          go_done = 1'b1;
        end else begin
          idx_n    = idx_q + CW'(1);
          go_issue = 1'b1;
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase

    if (go_issue) begin
      state_n = ST_ISSUE;
      rs_n    = a_n[idx_n];
      rt_n    = sel_n[1] ? {7'b0, cy_n} : b_n[idx_n];
      op_n    = sel_to_op(sel_n);
    end

    if (go_done) begin
      state_n  = ST_DONE;
      done_n   = 1'b1;
      result_n = r_n;
      carry_n  = cy_n;
      neg_n    = r_n[NBYTES-1][7];
      zero_n   = (r_n == '0);
    end
  end

endmodule

// File: tb/tb_mp_alu_seq.sv
// Self-checking bench for mp_alu_seq: a behavioural byte ALU, a full-width
// arithmetic reference model, directed cases and randomized operations.
module tb_mp_alu_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  localparam logic [8:0] OP_ADD  = 9'h002;
  localparam logic [8:0] OP_SUB  = 9'h006;
  localparam logic [8:0] OP_LSLC = 9'h00C;
  localparam logic [8:0] OP_LSRC = 9'h01C;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic [1:0]   op_sel_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin;
  logic [7:0]   alu_rs;
  logic [7:0]   alu_rt;
  logic [8:0]   alu_op;
  logic [7:0]   alu_res;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         carry_o;
  logic         neg_o;
  logic         zero_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  logic [W-1:0] held = '0;
  logic [8:0] opq[$];

  mp_alu_seq #(.NBYTES(NB)) dut (
    .clk          (clk),
    .reset_n      (rst_n),
    .start_i      (start_i),
    .op_sel_i     (op_sel_i),
    .a_i          (a_i),
    .b_i          (b_i),
`ifdef MP_CARRY_IN_EN
    .carry_i      (cin),
`endif
    .alu_rs_o     (alu_rs),
    .alu_rt_o     (alu_rt),
    .alu_op_o     (alu_op),
    .alu_result_i (alu_res),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .carry_o      (carry_o),
    .neg_o        (neg_o),
    .zero_o       (zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational byte ALU
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_res = alu_rs + alu_rt;
      OP_SUB:  alu_res = alu_rs - alu_rt;
      OP_LSLC: alu_res = {alu_rs[6:0], alu_rt[0]};
      OP_LSRC: alu_res = {alu_rt[0], alu_rs[7:1]};
      default: alu_res = 8'h00;
    endcase
  end

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  function automatic logic [8:0] sel_code(input logic [1:0] s);
    case (s)
      2'b00:   return OP_ADD;
      2'b01:   return OP_SUB;
      2'b10:   return OP_LSLC;
      default: return OP_LSRC;
    endcase
  endfunction

  // Full-width reference: result, final carry and per-byte carry-in vector
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic ci, output logic [W-1:0] r, output logic c,
                                output logic [NB-1:0] cv);
    logic [W:0] s, m, lo_a, lo_b;
    cv = '0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b} + (W+1)'(ci);
        r = s[W-1:0];
        c = s[W];
      end
      2'b01: begin
        r = a - b - W'(ci);
        c = ({1'b0, a} < ({1'b0, b} + (W+1)'(ci)));
      end
      2'b10: begin
        r = {a[W-2:0], ci};
        c = a[W-1];
      end
      default: begin
        r = {ci, a[W-1:1]};
        c = a[0];
      end
    endcase
    if (!op[1]) begin
      for (int i = 0; i < int'(NB); i++) begin
        m    = ((W+1)'(1) << (8 * i)) - (W+1)'(1);
        lo_a = {1'b0, a} & m;
        lo_b = {1'b0, b} & m;
        if (op[0]) cv[i] = (lo_a < (lo_b + (W+1)'(ci)));
        else       cv[i] = ((lo_a + lo_b + (W+1)'(ci)) > m);
      end
    end
  endfunction

  // Per-cycle compare: NOP while idle, result holds between operations
  always @(negedge clk) begin
    if (!rst_n) begin
      held = '0;
    end else begin
      if (!busy_o) check("idle_nop", 64'(alu_op), 64'h0);
      if (done_o) begin
        check("done_while_busy", 64'(busy_o), 64'h1);
        held = result_o;
        n_done++;
      end else begin
        check("result_hold", 64'(result_o), 64'(held));
      end
      if (alu_op != 9'h000) opq.push_back(alu_op);
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, output logic [W-1:0] r_got, output logic c_got,
                        output int lat);
    logic [W-1:0]  r_exp;
    logic          c_exp;
    logic [NB-1:0] cv;
    logic [8:0]    code;
    logic [8:0]    exp_seq[$];
    int            nfix;
    model(op, a, b, cin, r_exp, c_exp, cv);
    nfix = $countones(cv);
    code = sel_code(op);
    exp_seq = {};
    for (int i = 0; i < int'(NB); i++) begin
      exp_seq.push_back(code);
      if (cv[i]) exp_seq.push_back(code);
    end
    opq.delete();
    @(negedge clk);
    start_i = 1'b1; op_sel_i = op; a_i = a; b_i = b;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
      if (poke && k == 2) begin
        start_i = 1'b1; op_sel_i = ~op; a_i = $urandom; b_i = $urandom;
      end
      if (poke && k == 3) start_i = 1'b0;
      if (done_o) begin
        lat = k;
        break;
      end
    end
    check("latency", 64'(lat), 64'(NB + nfix + 1));
    r_got = result_o;
    c_got = carry_o;
    check("result", 64'(result_o), 64'(r_exp));
    check("carry", 64'(carry_o), 64'(c_exp));
    check("neg", 64'(neg_o), 64'(r_exp[W-1]));
    check("zero", 64'(zero_o), 64'(r_exp == '0));
    check("busy_in_done", 64'(busy_o), 64'h1);
    check("op_seq_len", 64'(opq.size()), 64'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < opq.size(); i++)
      check("op_seq", 64'(opq[i]), 64'(exp_seq[i]));
    @(negedge clk);
    check("done_one_cycle", 64'(done_o), 64'h0);
    check("idle_after_done", 64'(busy_o), 64'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] r;
    logic         c;
    int           lat;
    int           d0;
    logic [1:0]   op;
    logic [W-1:0] a, b;

    rst_n = 1'b0; start_i = 1'b0; op_sel_i = 2'b00; a_i = '0; b_i = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_done", 64'(done_o), 64'h0);
    check("rst_result", 64'(result_o), 64'h0);
    check("rst_flags", 64'({carry_o, neg_o, zero_o}), 64'h0);
    check("rst_op", 64'(alu_op), 64'h0);
    check("rst_operands", 64'({alu_rs, alu_rt}), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 32'h0000_00FF, 32'h0000_0001, 1'b0, r, c, lat);
    check("lit_add1_res", 64'(r), 64'h100);
    check("lit_add1_c", 64'(c), 64'h0);
    check("lit_add1_lat", 64'(lat), 64'd6);

    run_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, r, c, lat);
    check("lit_add2_res", 64'(r), 64'h0);
    check("lit_add2_c", 64'(c), 64'h1);
    check("lit_add2_lat", 64'(lat), 64'd8);
    check("lit_add2_zero", 64'(zero_o), 64'h1);
    check("lit_add2_neg", 64'(neg_o), 64'h0);

    run_op(2'b01, 32'h0000_0000, 32'h0000_0001, 1'b0, r, c, lat);
    check("lit_sub_res", 64'(r), 64'hFFFF_FFFF);
    check("lit_sub_b", 64'(c), 64'h1);
    check("lit_sub_neg", 64'(neg_o), 64'h1);

    run_op(2'b10, 32'h8000_0001, 32'h0, 1'b0, r, c, lat);
    check("lit_lsl_res", 64'(r), 64'h2);
    check("lit_lsl_c", 64'(c), 64'h1);
    check("lit_lsl_lat", 64'(lat), 64'd5);

    run_op(2'b11, 32'h0000_0003, 32'h0, 1'b0, r, c, lat);
    check("lit_lsr_res", 64'(r), 64'h1);
    check("lit_lsr_c", 64'(c), 64'h1);
    check("lit_lsr_lat", 64'(lat), 64'd5);

    // start pulsed mid-operation must not disturb or queue
    run_op(2'b00, 32'h0000_00FF, 32'h0000_0001, 1'b1, r, c, lat);
    check("lit_poke_res", 64'(r), 64'h100);
    check("lit_poke_lat", 64'(lat), 64'd6);

    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = ~a;
        2: b = a + 32'd1;
        default: b = 32'($urandom_range(0, 3));
      endcase
`ifdef MP_CARRY_IN_EN
      cin = 1'($urandom_range(0, 1));
`endif
      run_op(op, a, b, 1'b0, r, c, lat);
    end
    cin = 1'b0;

    // reset mid-operation aborts without a done pulse
    run_op(2'b00, 32'h1, 32'h1, 1'b0, r, c, lat);
    @(negedge clk);
    start_i = 1'b1; op_sel_i = 2'b00; a_i = 32'hFFFF_FFFF; b_i = 32'h1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy_o), 64'h0);
    check("mid_rst_result", 64'(result_o), 64'h0);
    check("mid_rst_done", 64'(done_o), 64'h0);
    check("mid_rst_op", 64'(alu_op), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_rst_no_done", 64'(n_done), 64'(d0));
    check("mid_rst_idle", 64'(busy_o), 64'h0);

    run_op(2'b00, 32'h1, 32'h2, 1'b0, r, c, lat);
    check("lit_after_rst", 64'(r), 64'h3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mp_alu_seq.md
Name: mp_alu_seq

Overview:
- Multi-precision arithmetic sequencer and initiator of the combinational byte ALU.
- Accepts one NBYTES-wide operation from the control path and issues a sequence of byte operations to the ALU (ADD, SUB, LSLC, LSRC).
- Samples each ALU result and reassembles the full-width result with carry/neg/zero flags.
- Sits beside the ALU and shares its operand and opcode ports via the datapath mux while busy.

Parameters:
- NBYTES, 4, operand width in bytes (≥2).
- CW, $clog2(NBYTES), width of the byte index counter.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle request; sampled only in IDLE.
- op_sel_i  input  2  00 ADD, 01 SUB, 10 shift left by 1, 11 shift right by 1.
- a_i  input  8*NBYTES  operand A, captured on accepted start.
- b_i  input  8*NBYTES  operand B, captured on accepted start; ignored for shifts.
- alu_rs_o  output  8  ALU operand s.
- alu_rt_o  output  8  ALU operand t.
- alu_op_o  output  9  ALU opcode, definitions encoding in bits [8:1], bit 0 = 0.
- alu_result_i  input  8  ALU result byte, same cycle.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse when the result is valid.
- result_o  output  8*NBYTES  registered full-width result.
- carry_o  output  1  final carry (ADD), borrow (SUB) or shifted-out bit.
- neg_o  output  1  result_o MSB.
- zero_o  output  1  result_o == 0.

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE.
  - All outputs 0; alu_op_o = 0 (NOP).
  - Operand, index and carry registers cleared.
- FSM states: IDLE, ISSUE, FIXUP, DONE.
- IDLE:
  - start_i=1 captures a_i, b_i and op_sel_i.
  - Clears the carry register and sets idx=0 for ADD/SUB/LSL, idx=NBYTES-1 for LSR.
  - Goes to ISSUE.
  - start_i while not IDLE is ignored; no queuing.
- ISSUE (ADD/SUB):
  - Drives rs=A[idx], rt=B[idx], op=ADD/SUB.
  - Registers the ALU result into R[idx].
  - Derives the byte carry locally from MSBs: carry = a7&b7 | (a7|b7)&~r7; borrow = ~a7&b7 | (~a7|b7)&r7.
  - The ALU carry output is not used: its carry is sign-extended and not the unsigned carry.
  - If the carry register (from the previous byte) is 1, go to FIXUP; otherwise latch the new carry and advance idx.
- FIXUP:
  - Drives rs=R[idx], rt=8'h01, same op.
  - Writes the result back to R[idx].
  - carry = carry_from_ISSUE OR carry from this step (same MSB rules).
  - Advances idx.
- ISSUE (shifts):
  - LSL: LSLC with op[3:2]=2'b11, rs=A[idx], rt={7'b0,carry}; carry←A[idx][7]; idx increments.
  - LSR: LSRC with op[3:2]=2'b11, rt={7'b0,carry}; carry←A[idx][0]; idx decrements.
- After the last byte, go to DONE.
- DONE:
  - result_o, carry_o, neg_o and zero_o update.
  - done_o=1 for exactly one cycle.
  - Then IDLE.
- busy_o=1 in ISSUE/FIXUP/DONE.
- result_o and flags hold between operations.
- Latency, start to done:
  - ADD/SUB: NBYTES + (number of bytes entered with carry-in=1) + 1.
  - Shifts: NBYTES + 1.
- Byte 0 never enters FIXUP: initial carry is 0.
- alu_op_o = 0 in IDLE and DONE.
- Reset mid-operation aborts immediately; no done_o.

Optional Feature:
- MP_CARRY_IN_EN: when defined, adds port carry_i (input, 1), captured at start as the initial carry/borrow/shift-in bit.
  - Byte 0 may then take FIXUP.
- Without the macro: initial carry is 0 and there is no port.

Test Plan:
- ADD 0x000000FF+0x00000001 -> result 0x00000100, carry 0, zero 0, done 6 cycles after start (byte1 takes FIXUP).
- ADD 0xFFFFFFFF+0x00000001 -> result 0, carry 1, zero 1, neg 0, done 8 cycles after start.
- SUB 0x00000000-0x00000001 -> result 0xFFFFFFFF, carry (borrow) 1, neg 1.
- Shift left 0x80000001 -> 0x00000002, carry 1; shift right 0x00000003 -> 0x00000001, carry 1; each done 5 cycles after start.
- start_i pulsed while busy -> ignored, first result unchanged; reset_n low mid-ADD -> busy 0, result 0, no done pulse.
- alu_op_o monitor -> exactly the expected ADD/SUB/LSLC/LSRC byte sequence, NOP while idle.
